// File: rtl/video_types_pkg.sv
// Shared video constants, register addresses and PPU mode encoding for the
// scanline timing generator and the renderer downstream of it.
package video_types;

  localparam int unsigned DOTS_PER_LINE   = 456;
  localparam int unsigned LINES_PER_FRAME = 154;
  localparam int unsigned VISIBLE_LINES   = 144;
  localparam int unsigned OAM_DOTS        = 80;
  localparam int unsigned XFER_DOTS       = 172;

  localparam logic [15:0] STAT_ADDR = 16'hFF41;
  localparam logic [15:0] LY_ADDR   = 16'hFF44;
  localparam logic [15:0] LYC_ADDR  = 16'hFF45;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    TRANSFER = 2'd3
  } lcd_mode_t;

endpackage

// File: rtl/lcd_timing.sv
// Dot/line timing generator: PPU mode, drawline/frame strobes, VBlank and STAT
// interrupts, and the STAT/LY/LYC registers.
module lcd_timing #(
  parameter int unsigned DOTS_PER_LINE   = video_types::DOTS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = video_types::LINES_PER_FRAME,
  parameter int unsigned VISIBLE_LINES   = video_types::VISIBLE_LINES,
  parameter int unsigned OAM_DOTS        = video_types::OAM_DOTS,
  parameter int unsigned XFER_DOTS       = video_types::XFER_DOTS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_enable,
  input  logic [15:0] reg_addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        reg_oe,
  output logic        drawline,
  output logic        frame_start,
  output logic [1:0]  mode,
  output logic [7:0]  ly,
  output logic        vblank_irq,
  output logic        stat_irq
);
  import video_types::*;

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic [7:0] lyc_q, lyc_d;
  logic [3:0] en_q, en_d;
  logic       active_q, active_d;
  lcd_mode_t  mode_q, mode_d;
  logic       drawline_q, drawline_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_q, vblank_d;
  logic       cond_q, cond_d;
  logic       coin, cond;

  // Mode and strobes are computed from the next dot/ly so the registered
  // outputs line up with the counter values of the same cycle.
  always_comb begin
    active_d = lcd_enable;
    dot_d    = '0;
    ly_d     = '0;
    if (lcd_enable && active_q) begin
      if (dot_q == 9'(DOTS_PER_LINE - 1)) begin
        ly_d = (ly_q == 8'(LINES_PER_FRAME - 1)) ? '0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
        ly_d  = ly_q;
      end
    end

    mode_d = HBLANK;
    if (active_d) begin
      if (ly_d >= 8'(VISIBLE_LINES))               mode_d = VBLANK;
      else if (dot_d < 9'(OAM_DOTS))               mode_d = OAM_SCAN;
      else if (dot_d < 9'(OAM_DOTS + XFER_DOTS))   mode_d = TRANSFER;
      else                                         mode_d = HBLANK;
    end

    drawline_d    = active_d && (ly_d < 8'(VISIBLE_LINES)) && (dot_d == 9'(OAM_DOTS));
    frame_start_d = active_d && (ly_d == '0) && (dot_d == '0);
    vblank_d      = active_d && (ly_d == 8'(VISIBLE_LINES)) && (dot_d == '0);
  end

  always_comb begin
    en_d  = en_q;
    lyc_d = lyc_q;
    if (reg_wr && reg_addr == STAT_ADDR) en_d  = reg_wdata[6:3];
    if (reg_wr && reg_addr == LYC_ADDR)  lyc_d = reg_wdata;
  end

  // Gated by active_q so a disabled LCD never raises STAT.
  always_comb begin
    coin   = (ly_q == lyc_q);
    cond   = active_q & ((en_q[3] & coin) |
                         (en_q[2] & (mode_q == OAM_SCAN)) |
                         (en_q[1] & (mode_q == VBLANK)) |
                         (en_q[0] & (mode_q == HBLANK)));
    cond_d = cond;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dot_q         <= '0;
      ly_q          <= '0;
      lyc_q         <= '0;
      en_q          <= '0;
      active_q      <= 1'b0;
      mode_q        <= HBLANK;
      drawline_q    <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
      cond_q        <= 1'b0;
    end else begin
      dot_q         <= dot_d;
      ly_q          <= ly_d;
      lyc_q         <= lyc_d;
      en_q          <= en_d;
      active_q      <= active_d;
      mode_q        <= mode_d;
      drawline_q    <= drawline_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
      cond_q        <= cond_d;
    end
  end

  always_comb begin
    reg_oe    = 1'b0;
    reg_rdata = '0;
    if (reg_rd) begin
      case (reg_addr)
        STAT_ADDR: begin reg_oe = 1'b1; reg_rdata = {1'b1, en_q, coin, mode_q}; end
        LY_ADDR:   begin reg_oe = 1'b1; reg_rdata = ly_q;  end
        LYC_ADDR:  begin reg_oe = 1'b1; reg_rdata = lyc_q; end
        default:   begin reg_oe = 1'b0; reg_rdata = '0;    end
      endcase
    end
  end

  assign drawline    = drawline_q;
  assign frame_start = frame_start_q;
  assign vblank_irq  = vblank_q;
  assign stat_irq    = cond & ~cond_q;
  assign mode        = mode_q;
  assign ly          = ly_q;

endmodule

// File: tb/tb_lcd_timing.sv
// Directed bench for lcd_timing: line/frame timing, strobes, LYC/STAT
// interrupts, register access, enable toggling and asynchronous reset.
module tb_lcd_timing;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        reset;
  logic        lcd_enable;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        reg_oe;
  logic        drawline;
  logic        frame_start;
  logic [1:0]  mode;
  logic [7:0]  ly;
  logic        vblank_irq;
  logic        stat_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs = 0;
  int fs_gap = 0;
  int n_draw = 0;
  int n_fs = 0;
  int n_vbl = 0;
  int n_stat = 0;

  lcd_timing dut (
    .clk(clk), .reset(reset), .lcd_enable(lcd_enable),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_oe(reg_oe),
    .drawline(drawline), .frame_start(frame_start), .mode(mode), .ly(ly),
    .vblank_irq(vblank_irq), .stat_irq(stat_irq)
  );

  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_start) begin
        fs_gap  = cyc - last_fs;
        last_fs = cyc;
        n_fs++;
      end
      if (drawline)   n_draw++;
      if (vblank_irq) n_vbl++;
      if (stat_irq)   n_stat++;
    end
  endtask

  task automatic clr_counts();
    n_draw = 0; n_fs = 0; n_vbl = 0; n_stat = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    adv(1);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp, input logic exp_oe);
    reg_addr = a; reg_rd = 1'b1;
    #1;
    chk(tag, 16'(reg_rdata), 16'(exp));
    chk({tag, "_oe"}, 16'(reg_oe), 16'(exp_oe));
    reg_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lcd_enable = 1'b0;
    reg_addr = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = '0;
    adv(2);
    reset = 1'b0;
    adv(1);
    chk("rst_ly", 16'(ly), 16'd0);
    chk("rst_mode", 16'(mode), 16'd0);
    chk("rst_fs", 16'(frame_start), 16'd0);

    // Register setup while disabled; STAT keeps only bits 6:3, LY ignores writes.
    wr(16'hFF45, 8'h05);
    wr(16'hFF41, 8'hC7);
    wr(16'hFF44, 8'h33);
    rd("ly_rd", 16'hFF44, 8'h00, 1'b1);
    rd("lyc_rd", 16'hFF45, 8'h05, 1'b1);
    rd("stat_rd_dis", 16'hFF41, 8'hC0, 1'b1);
    rd("miss_rd", 16'hFF40, 8'h00, 1'b0);
    chk("dis_stat_irq", 16'(stat_irq), 16'd0);

    lcd_enable = 1'b1;
    adv(1);
    chk("en_fs", 16'(frame_start), 16'd1);
    chk("en_mode", 16'(mode), 16'd2);
    chk("en_ly", 16'(ly), 16'd0);
    adv(79);
    chk("d79_mode", 16'(mode), 16'd2);
    chk("d79_draw", 16'(drawline), 16'd0);
    adv(1);
    chk("d80_mode", 16'(mode), 16'd3);
    chk("d80_draw", 16'(drawline), 16'd1);
    adv(171);
    chk("d251_mode", 16'(mode), 16'd3);
    adv(1);
    chk("d252_mode", 16'(mode), 16'd0);
    adv(203);
    chk("d455_ly", 16'(ly), 16'd0);
    chk("d455_mode", 16'(mode), 16'd0);
    adv(1);
    chk("l1_ly", 16'(ly), 16'd1);
    chk("l1_mode", 16'(mode), 16'd2);

    adv(3 * 456 + 455);
    chk("l4_ly", 16'(ly), 16'd4);
    chk("l4_stat_irq", 16'(stat_irq), 16'd0);
    adv(1);
    chk("lyc_ly", 16'(ly), 16'd5);
    chk("lyc_stat_irq", 16'(stat_irq), 16'd1);
    adv(1);
    chk("lyc_once", 16'(stat_irq), 16'd0);
    rd("stat_rd_l5", 16'hFF41, 8'hC6, 1'b1);
    rd("ly_rd_l5", 16'hFF44, 8'h05, 1'b1);

    // Line 5 dot 1 -> line 10 dot 100, then drop enable mid-transfer.
    adv(5 * 456 + 99);
    chk("l10_ly", 16'(ly), 16'd10);
    chk("l10_mode", 16'(mode), 16'd3);
    lcd_enable = 1'b0;
    adv(1);
    chk("off_ly", 16'(ly), 16'd0);
    chk("off_mode", 16'(mode), 16'd0);
    chk("off_draw", 16'(drawline), 16'd0);
    clr_counts();
    adv(100);
    chk("off_pulses", 16'(n_draw + n_fs + n_vbl + n_stat), 16'd0);
    wr(16'hFF41, 8'h18);
    chk("off_stat_irq", 16'(stat_irq), 16'd0);

    lcd_enable = 1'b1;
    adv(1);
    chk("reen_fs", 16'(frame_start), 16'd1);
    chk("reen_mode", 16'(mode), 16'd2);
    clr_counts();
    adv(80);
    chk("reen_draw", 16'(drawline), 16'd1);
    adv(143 * 456 + 251 - 80);
    chk("l143_ly", 16'(ly), 16'd143);
    chk("l143_mode", 16'(mode), 16'd3);
    adv(1);
    chk("l143_m0", 16'(mode), 16'd0);
    chk("l143_stat_irq", 16'(stat_irq), 16'd1);
    adv(203);
    chk("l143_end_irq", 16'(stat_irq), 16'd0);
    adv(1);
    chk("vbl_ly", 16'(ly), 16'd144);
    chk("vbl_mode", 16'(mode), 16'd1);
    chk("vbl_irq", 16'(vblank_irq), 16'd1);
    chk("vbl_blocked", 16'(stat_irq), 16'd0);
    adv(4559);
    chk("l153_ly", 16'(ly), 16'd153);
    chk("l153_mode", 16'(mode), 16'd1);
    chk("l153_fs", 16'(frame_start), 16'd0);
    adv(1);
    chk("f2_fs", 16'(frame_start), 16'd1);
    chk("f2_mode", 16'(mode), 16'd2);
    chk("frame_gap", 16'(fs_gap), 16'(70224));
    chk("frame_draws", 16'(n_draw), 16'd144);
    chk("frame_vbl", 16'(n_vbl), 16'd1);
    chk("frame_fs", 16'(n_fs), 16'd1);
    chk("frame_stat", 16'(n_stat), 16'd144);

    adv(2 * 456 + 10);
    chk("pre_rst_ly", 16'(ly), 16'd2);
    chk("pre_rst_mode", 16'(mode), 16'd2);
    clk_run = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ly", 16'(ly), 16'd0);
    chk("arst_mode", 16'(mode), 16'd0);
    chk("arst_strobes", 16'({drawline, frame_start, vblank_irq, stat_irq}), 16'd0);
    rd("arst_stat", 16'hFF41, 8'h84, 1'b1);
    rd("arst_lyc", 16'hFF45, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
